gray_to_binary_reg: RTL and testbench
=====================================

Name: gray_to_binary_reg

Overview:
- Registered Gray-code to natural-binary converter.
- Accepts one Gray word per valid cycle and returns its binary value one clock later.
- Also flags input sequences that break Gray adjacency, i.e. consecutive accepted codes that differ in more than one bit.
- Sits between Gray-coded sources (encoders, async-FIFO pointers, counters) and binary arithmetic logic.

Parameters:
- WIDTH, 4, Gray/binary word width (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  g is valid this cycle.
- g  input  WIDTH  Gray code input. g[WIDTH-1] is MSB; at WIDTH=4, g[3..0] = g3,g2,g1,g0.
- err_clr  input  1  synchronous clear of err_sticky.
- out_valid  output  1  bin and step_err are valid this cycle.
- bin  output  WIDTH  binary result. At WIDTH=4, bin[3..0] = d,c,b,a (d = MSB).
- step_err  output  1  current word differs from the previous accepted word in more than one bit.
- err_sticky  output  1  latched OR of step_err since reset or the last err_clr.

Behaviour:
- Conversion (pure combinational core):
  - bin[WIDTH-1] = g[WIDTH-1].
  - bin[i] = bin[i+1] XOR g[i], for i = WIDTH-2 down to 0.
  - Equivalently, bin[i] = XOR of g[WIDTH-1:i].
- Latency and throughput:
  - Exactly 1 cycle: when in_valid=1 at edge k, out_valid=1 and bin/step_err are valid after edge k.
  - One word per cycle.
  - No backpressure; out_valid is a pulse per accepted word.
- Idle cycles: when in_valid=0, out_valid=0 next cycle, and bin and step_err hold their last values.
- Adjacency check:
  - The block keeps prev_g and a has_prev flag.
  - On each accepted word, step_err = has_prev AND (popcount(g XOR prev_g) > 1).
  - Hamming distance 0 (repeated code) or 1 is not an error.
  - The accepted word then becomes prev_g, and has_prev is set to 1.
  - The first word after reset never flags.
  - Wrap-around (e.g. 1000 -> 0000 at WIDTH=4) is distance 1, so it is legal.
- Sticky error:
  - err_sticky sets on any cycle where step_err is asserted with out_valid.
  - err_clr=1 clears err_sticky on the next edge.
  - If err_clr coincides with a new error, set wins and err_sticky stays 1.
- Reset (asynchronous, active-high):
  - All of the following go to 0 immediately: out_valid, bin, step_err, err_sticky, prev_g, has_prev.
  - A word in flight during reset is discarded.
  - After rst deasserts, the next accepted word is treated as the first.
- Signed/width rules: all values are unsigned. No overflow is possible, because the output width equals the input width.

Decomposition:
- Shared package gray_pkg:
  - default WIDTH constant.
  - function gray2bin(logic [WIDTH-1:0]).
  - function popcount / onehot-or-zero check.
- One natural sub-module: gray2bin_comb, a purely combinational XOR prefix chain.
- The top level instantiates gray2bin_comb and adds the pipeline register, previous-code register and error logic.

Test Plan:
- Reset:
  - Assert rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
  - After release, send g=0110 -> bin=0100 one cycle later, and step_err=0 because this is the first word.
- Full 4-bit Gray sequence:
  - Inputs 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, one per cycle with in_valid=1.
  - Expected bin = 0..15 in order, each one cycle after its input.
  - step_err=0 throughout.
- Spot values:
  - g=1000 -> bin=1111.
  - g=1100 -> bin=1000.
  - g=0010 -> bin=0011.
  - g=1111 -> bin=1010.
- Adjacency violation:
  - 0001 then 0111 -> step_err=1 on the second output, and err_sticky=1 thereafter.
  - Wrap 1000 -> 0000 -> step_err=0.
  - Repeat 0101, 0101 -> step_err=0.
- Sticky clear:
  - err_clr=1 alone -> err_sticky=0 next cycle.
  - err_clr=1 in the same cycle as a violating word -> err_sticky remains 1.
- Gaps:
  - in_valid toggled 1,0,0,1 with words 0011 and 0010 -> out_valid pulses twice.
  - bin holds 0010 during the gap, then becomes 0011.
  - step_err=0 for both words.

Source files
------------

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared width constant and Gray-code helper functions
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  // Helpers work on the widest legal word; callers zero-extend narrower values.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_WIDTH-1:0] x);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      n = n + {5'd0, x[i]};
    end
    return n;
  endfunction

  function automatic logic is_onehot_or_zero(input logic [MAX_WIDTH-1:0] x);
    return (x & (x - MAX_WIDTH'(1))) == '0;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// rtl/gray2bin_comb.sv - combinational Gray-to-binary XOR prefix chain
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of every Gray bit at or above it.
  always_comb begin
    bin_o = '0;
    bin_o[WIDTH-1] = g_i[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ g_i[i];
    end
  end

endmodule

// File: rtl/gray_to_binary_reg.sv
// rtl/gray_to_binary_reg.sv - registered Gray-to-binary converter with adjacency checking
module gray_to_binary_reg
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] g,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin,
  output logic             step_err,
  output logic             err_sticky
);

  logic [WIDTH-1:0]     bin_c;
  logic [MAX_WIDTH-1:0] diff_c;
  logic                 step_err_d;
  logic                 err_sticky_d;

  logic                 out_valid_q;
  logic [WIDTH-1:0]     bin_q;
  logic                 step_err_q;
  logic                 err_sticky_q;
  logic [WIDTH-1:0]     prev_g_q;
  logic                 has_prev_q;

  gray2bin_comb #(.WIDTH(WIDTH)) u_conv (
    .g_i   (g),
    .bin_o (bin_c)
  );

  always_comb begin
    diff_c = '0;
    diff_c[WIDTH-1:0] = g ^ prev_g_q;
    step_err_d = has_prev_q && !is_onehot_or_zero(diff_c);
    // A fresh violation outranks a coincident clear.
    err_sticky_d = (err_sticky_q && !err_clr) || (in_valid && step_err_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      bin_q        <= '0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      prev_g_q     <= '0;
      has_prev_q   <= 1'b0;
    end else begin
      out_valid_q  <= in_valid;
      err_sticky_q <= err_sticky_d;
      if (in_valid) begin
        bin_q      <= bin_c;
        step_err_q <= step_err_d;
        prev_g_q   <= g;
        has_prev_q <= 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign bin        = bin_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_gray_to_binary_reg.sv
// tb/tb_gray_to_binary_reg.sv - scoreboard bench for gray_to_binary_reg
module tb_gray_to_binary_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] g;
  logic       err_clr;
  logic       out_valid;
  logic [3:0] bin;
  logic       step_err;
  logic       err_sticky;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] exp_q[$];
  logic [3:0] m_prev;
  logic       m_has_prev;
  logic       m_sticky;
  logic [3:0] m_last_bin;
  logic       m_last_err;

  gray_to_binary_reg #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .g          (g),
    .err_clr    (err_clr),
    .out_valid  (out_valid),
    .bin        (bin),
    .step_err   (step_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_bin(input logic [3:0] gv);
    logic [3:0] b;
    b = gv ^ (gv >> 1) ^ (gv >> 2) ^ (gv >> 3);
    return b;
  endfunction

  function automatic int model_dist(input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_prev     = '0;
    m_has_prev = 1'b0;
    m_sticky   = 1'b0;
    m_last_bin = '0;
    m_last_err = 1'b0;
  endtask

  // Drives one cycle of stimulus (called just after a falling edge) and checks the response.
  task automatic step(input logic v, input logic [3:0] gv, input logic clr);
    logic       e;
    logic [4:0] ent;
    in_valid = v;
    g        = gv;
    err_clr  = clr;
    e = 1'b0;
    if (v) begin
      e = m_has_prev && (model_dist(gv, m_prev) > 1);
      exp_q.push_back({model_bin(gv), e});
      m_prev     = gv;
      m_has_prev = 1'b1;
    end
    m_sticky = (m_sticky && !clr) || (v && e);
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, v);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        ent = exp_q.pop_front();
        check($sformatf("bin g=%b", gv), bin, ent[4:1]);
        check($sformatf("step_err g=%b", gv), step_err, ent[0]);
        m_last_bin = ent[4:1];
        m_last_err = ent[0];
      end
    end else begin
      check("bin_hold", bin, m_last_bin);
      check("step_err_hold", step_err, m_last_err);
    end
    check("err_sticky", err_sticky, m_sticky);
  endtask

  initial begin
    logic [3:0] seq [16];
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    rst = 1'b1; in_valid = 1'b0; g = '0; err_clr = 1'b0;
    model_reset();
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_bin", bin, 0);
    check("reset_sticky", err_sticky, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(1'b1, seq[i], 1'b0);
      check("seq_bin_count", bin, i);
    end

    step(1'b1, 4'b1000, 1'b0); check("spot_1000", bin, 4'b1111);
    step(1'b1, 4'b1100, 1'b0); check("spot_1100", bin, 4'b1000);
    step(1'b1, 4'b0010, 1'b0); check("spot_0010", bin, 4'b0011);
    step(1'b1, 4'b1111, 1'b0); check("spot_1111", bin, 4'b1010);

    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0111, 1'b0); check("violation_flag", step_err, 1);
    step(1'b0, 4'b0000, 1'b0); check("violation_sticky", err_sticky, 1);
    step(1'b0, 4'b0000, 1'b1); check("clr_alone", err_sticky, 0);

    step(1'b1, 4'b1000, 1'b0);
    step(1'b1, 4'b0000, 1'b0); check("wrap_ok", step_err, 0);
    step(1'b1, 4'b0101, 1'b0);
    step(1'b1, 4'b0101, 1'b0); check("repeat_ok", step_err, 0);
    step(1'b1, 4'b0000, 1'b1); check("clr_vs_set", err_sticky, 1);
    step(1'b0, 4'b0000, 1'b1);

    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0011, 1'b0); check("gap_first", bin, 4'b0010);
    step(1'b0, 4'b0000, 1'b0); check("gap_hold1", bin, 4'b0010);
    step(1'b0, 4'b0000, 1'b0); check("gap_hold2", bin, 4'b0010);
    step(1'b1, 4'b0010, 1'b0); check("gap_second", bin, 4'b0011);
    check("gap_no_err", step_err, 0);

    // Violate so sticky is set, then reset mid-cycle with a word in flight.
    step(1'b1, 4'b1111, 1'b0);
    in_valid = 1'b1; g = 4'b1010; err_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_bin", bin, 0);
    check("async_step_err", step_err, 0);
    check("async_sticky", err_sticky, 0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'b0110, 1'b0);
    check("post_reset_bin", bin, 4'b0100);
    check("post_reset_first", step_err, 0);
    step(1'b0, 4'b0000, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
